// File: rtl/mash_pkg.sv
// Shared constants and the LFSR step function for the MASH accumulator slice.
package mash_pkg;

    localparam int unsigned ACC_W_DEF = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1 taps bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {^(state & LFSR_TAPS), state[15:1]};
    endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One accumulator stage: ACC_W-bit modulo adder, accumulator register and carry flop.
// sum_o is the combinational low sum, so the next stage chains within the same cycle.
module mash_acc_stage
    import mash_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] add_in,
    input  logic             cin,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;

    always_comb begin
        // Max of acc + add + cin is 2^(ACC_W+1)-1, so one carry bit suffices
        sum     = {1'b0, acc_q} + {1'b0, add_in} + {{ACC_W{1'b0}}, cin};
        acc_d   = acc_q;
        carry_d = carry_q;
        if (clr) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (en) begin
            acc_d   = sum[ACC_W-1:0];
            carry_d = sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign sum_o   = sum[ACC_W-1:0];
    assign carry_o = carry_q;

endmodule

// File: rtl/mash_accumulator.sv
// Three-stage MASH accumulator with frequency-word register and optional LFSR dither.
// Carries c1..c3 are registered and time-aligned for the downstream noise shaper.
module mash_accumulator
    import mash_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] k_in,
    input  logic             k_load,
    input  logic             dither_en,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic [ACC_W-1:0] k_active
);

    logic [ACC_W-1:0] k_reg_q, k_reg_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             dither_bit;
    logic [ACC_W-1:0] s1, s2, unused_s3;

    always_comb begin
        k_reg_d = k_load ? k_in : k_reg_q;
        lfsr_d  = lfsr_q;
        if (clr) begin
            lfsr_d = LFSR_SEED;
        end else if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
        dither_bit = dither_en & lfsr_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            k_reg_q <= k_reg_d;
            lfsr_q  <= lfsr_d;
        end
    end

    mash_acc_stage #(.ACC_W(ACC_W)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .add_in  (k_reg_q),
        .cin     (dither_bit),
        .sum_o   (s1),
        .carry_o (c1)
    );

    mash_acc_stage #(.ACC_W(ACC_W)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .add_in  (s1),
        .cin     (1'b0),
        .sum_o   (s2),
        .carry_o (c2)
    );

    mash_acc_stage #(.ACC_W(ACC_W)) u_stage3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .add_in  (s2),
        .cin     (1'b0),
        .sum_o   (unused_s3),
        .carry_o (c3)
    );

    assign k_active = k_reg_q;

endmodule
